pio_in_edge_irq: RTL and testbench



---
 rtl/pio_in_pkg.sv | 15 +
 rtl/pio_in_debounce.sv | 56 +++++
 rtl/pio_in_edge_irq.sv | 118 +++++++++++
 tb/tb_pio_in_edge_irq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_in_pkg.sv
// Shared constants for the edge-capturing input PIO: register word addresses
// and reset values of the edge-enable registers.
package pio_in_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RISE    = 3'd4;
  localparam logic [2:0] ADDR_FALL    = 3'd5;

  // Falling-edge-only out of reset keeps the old push-button behaviour.
  localparam logic [31:0] RISE_EN_RST = 32'h0000_0000;
  localparam logic [31:0] FALL_EN_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/pio_in_debounce.sv
// One input channel: metastability synchroniser, mismatch counter and debounced
// level, plus a strobe that is high in the cycle the debounced level is about to flip.
module pio_in_debounce
  import pio_in_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_s,
  output logic o_q,
  output logic o_change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_q;
  logic                   w_s;
  logic                   w_last;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_last   = (r_cnt == CNT_LAST);
  assign o_s      = w_s;
  assign o_q      = r_q;
  assign o_change = (w_s != r_q) && w_last;

  // Synchroniser shift chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

  // Count consecutive mismatch cycles; the counter is cleared before it can wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (w_s == r_q) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_q   <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: debounced pins, per-bit rise/fall edge capture with
// write-1-to-clear, and a level interrupt from the masked capture bits.
module pio_in_edge_irq
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_change;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_wr;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_capture;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [31:0]      r_readdata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pio_in_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .i_pin   (in_port[g]),
      .o_s     (w_s[g]),
      .o_q     (w_q[g]),
      .o_change(w_change[g])
    );
  end

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = &{1'b0, writedata};
  assign w_ev           = ((w_change & w_s) & r_rise_en) | ((w_change & ~w_s) & r_fall_en);

  // Clear mask for the capture register
  always_comb begin
    w_clr = '0;
    if (w_wr && (address == ADDR_CAPTURE)) begin
      w_clr = w_wdata;
    end else begin
      w_clr = '0;
    end
  end

  // Software-writable control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask    <= '0;
      r_rise_en <= RISE_EN_RST[WIDTH-1:0];
      r_fall_en <= FALL_EN_RST[WIDTH-1:0];
    end else if (w_wr) begin
      case (address)
        ADDR_MASK: r_mask    <= w_wdata;
        ADDR_RISE: r_rise_en <= w_wdata;
        ADDR_FALL: r_fall_en <= w_wdata;
        default:   ;
      endcase
    end
  end

  // Edge capture: a new event beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_capture <= '0;
    end else begin
      r_capture <= w_ev | (r_capture & ~w_clr);
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    w_rdata = 32'd0;
    case (address)
      ADDR_DATA:    w_rdata = 32'(w_q);
      ADDR_MASK:    w_rdata = 32'(r_mask);
      ADDR_CAPTURE: w_rdata = 32'(r_capture);
      ADDR_RISE:    w_rdata = 32'(r_rise_en);
      ADDR_FALL:    w_rdata = 32'(r_fall_en);
      default:      w_rdata = 32'd0;
    endcase
  end

  // Read data register, one cycle of latency regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_capture & r_mask);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Scoreboard bench for pio_in_edge_irq: directed scenarios plus random bus and
// pin traffic, checked against a sliding-window behavioural model.
module tb_pio_in_edge_irq;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HIST = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp_m;
    logic [31:0] exp_p;
    bit          has_p;
  } rd_t;
  rd_t sbq[$];

  logic        rd_strobe = 1'b0;
  string       plan_name = "";
  logic [31:0] plan_val  = 32'd0;
  bit          plan_has  = 1'b0;

  // reference model state
  logic [W-1:0] m_q, m_cap, m_mask, m_rise, m_fall;
  logic [W-1:0] m_hist [HIST];

  pio_in_edge_irq #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_q);
      3'd2:    return 32'(m_mask);
      3'd3:    return 32'(m_cap);
      3'd4:    return 32'(m_rise);
      3'd5:    return 32'(m_fall);
      default: return 32'd0;
    endcase
  endfunction

  // A pin's debounced level flips once its synchronised value has disagreed
  // with the current level on DEB consecutive clock edges.
  task automatic model_edge();
    logic [W-1:0] new_q, ev, clr;
    bit           wr, all_diff;
    rd_t          e;
    if (rd_strobe) begin
      e.name = plan_name; e.exp_m = model_read(address);
      e.exp_p = plan_val; e.has_p = plan_has;
      sbq.push_back(e);
    end
    new_q = m_q;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++)
        if (m_hist[SYNC-1+k][b] == m_q[b]) all_diff = 1'b0;
      if (all_diff) new_q[b] = ~m_q[b];
    end
    ev  = (new_q & ~m_q & m_rise) | (~new_q & m_q & m_fall);
    wr  = chipselect && !write_n;
    clr = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
    m_cap = ev | (m_cap & ~clr);
    if (wr && address == 3'd2) m_mask = writedata[W-1:0];
    if (wr && address == 3'd4) m_rise = writedata[W-1:0];
    if (wr && address == 3'd5) m_fall = writedata[W-1:0];
    m_q = new_q;
    for (int k = HIST-1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = in_port;
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_q = '0; m_cap = '0; m_mask = '0; m_rise = '0; m_fall = '1;
        for (int k = 0; k < HIST; k++) m_hist[k] = '0;
      end else begin
        model_edge();
      end
    end
  end

  initial begin : monitor
    rd_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        while (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk({e.name, "_model"}, readdata, e.exp_m);
          if (e.has_p) chk({e.name, "_plan"}, readdata, e.exp_p);
        end
        chk("irq_model", 32'(irq), 32'(|(m_cap & m_mask)));
      end
    end
  end

  task automatic rd(input logic [2:0] a, input string nm, input logic [31:0] pv, input bit hp);
    address = a; rd_strobe = 1'b1;
    plan_name = nm; plan_val = pv; plan_has = hp;
    @(posedge clk); @(negedge clk);
    rd_strobe = 1'b0; plan_has = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; in_port = '0;
    idle(3);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    idle(1);

    rd(3'd0, "rst_data", 32'h0, 1'b1);
    rd(3'd2, "rst_mask", 32'h0, 1'b1);
    rd(3'd3, "rst_cap",  32'h0, 1'b1);
    rd(3'd4, "rst_rise", 32'h0, 1'b1);
    rd(3'd5, "rst_fall", 32'hF, 1'b1);
    chk("rst_irq_after", 32'(irq), 32'd0);

    // exact latency: q changes on edge SYNC+DEB, visible on the following read
    in_port = 4'b0001;
    for (int i = 1; i <= SYNC + DEB + 1; i++)
      rd(3'd0, "latency", (i <= SYNC + DEB) ? 32'h0 : 32'h1, 1'b1);
    rd(3'd3, "rise_not_enabled", 32'h0, 1'b1);

    // glitch shorter than the debounce window
    in_port[0] = 1'b0; idle(3); in_port[0] = 1'b1;
    idle(8);
    rd(3'd0, "glitch_data", 32'h1, 1'b1);
    rd(3'd3, "glitch_cap",  32'h0, 1'b1);

    // rising edge capture and irq, then W1C
    wr(3'd4, 32'h2);
    wr(3'd2, 32'h2);
    in_port[1] = 1'b1;
    idle(SYNC + DEB + 1);
    rd(3'd3, "rise_cap", 32'h2, 1'b1);
    chk("rise_irq", 32'(irq), 32'd1);
    wr(3'd3, 32'h2);
    chk("w1c_irq", 32'(irq), 32'd0);
    rd(3'd3, "w1c_cap", 32'h0, 1'b1);

    // clear on the same edge a falling event is captured: set wins
    in_port[0] = 1'b0;
    idle(SYNC + DEB - 1);
    wr(3'd3, 32'h1);
    rd(3'd3, "set_wins", 32'h1, 1'b1);
    wr(3'd3, 32'h1);
    rd(3'd3, "plain_clear", 32'h0, 1'b1);

    // reset in the middle of debouncing
    in_port = 4'hF;
    idle(SYNC + 2);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    for (int i = 1; i <= SYNC + DEB + 1; i++)
      rd(3'd0, "rst_mid", (i <= SYNC + DEB) ? 32'h0 : 32'hF, 1'b1);
    rd(3'd3, "rst_mid_cap", 32'h0, 1'b1);
    chk("rst_mid_irq", 32'(irq), 32'd0);

    // random bus and pin traffic
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 3) == 0)
        in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
      case ($urandom_range(0, 3))
        0:       wr(3'($urandom_range(0, 7)), $urandom);
        1:       rd(3'($urandom_range(0, 7)), "rand_rd", 32'd0, 1'b0);
        2:       rd(3'd3, "rand_cap", 32'd0, 1'b0);
        default: idle(1);
      endcase
    end

    idle(3);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
